// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_memory port between p0 (LSU) and p1 (debug/DMA), one transaction in flight.
// Optional misaligned-access trapping is enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [31:0]       p0_req_wdata,
    input  logic              p0_req_write,
    input  logic [1:0]        p0_req_size,
    input  logic              p0_req_unsigned,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [31:0]       p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [31:0]       p1_req_wdata,
    input  logic              p1_req_write,
    input  logic [1:0]        p1_req_size,
    input  logic              p1_req_unsigned,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [31:0]       p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic              mem_unsigned_load,
    input  logic [31:0]       mem_read_data
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic        r_write;
    logic        r_misal;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_write_data;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [1:0]  r_mem_size;
    logic        r_mem_unsigned;
    logic [1:0]  r_rsp_valid;
    logic [1:0]  r_rsp_err;
    logic [31:0] r_rsp_rdata [2];

    logic              w_idle;
    logic              w_grant_p1;
    logic              w_handshake;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_write;
    logic [1:0]        w_sel_size;
    logic              w_sel_unsigned;
    logic              w_misal;
    logic [1:0]        w_rsp_ready;

    // Reset gates the ready pulses so every output reads 0 while reset is held.
    assign w_idle      = (r_state == S_IDLE) && !reset;
    assign w_grant_p1  = p1_req_valid && (!p0_req_valid || (!FIXED_PRIO && !r_last_grant));
    assign w_handshake = w_idle && (p0_req_valid || p1_req_valid);
    assign w_rsp_ready = {p1_rsp_ready, p0_rsp_ready};

    assign p0_req_ready = w_idle && p0_req_valid && !w_grant_p1;
    assign p1_req_ready = w_idle && w_grant_p1;

    assign w_sel_addr     = w_grant_p1 ? p1_req_addr     : p0_req_addr;
    assign w_sel_wdata    = w_grant_p1 ? p1_req_wdata    : p0_req_wdata;
    assign w_sel_write    = w_grant_p1 ? p1_req_write    : p0_req_write;
    assign w_sel_size     = w_grant_p1 ? p1_req_size     : p0_req_size;
    assign w_sel_unsigned = w_grant_p1 ? p1_req_unsigned : p0_req_unsigned;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign w_misal = ((w_sel_size == 2'b01) && w_sel_addr[0]) ||
                     ((w_sel_size == 2'b10) && (w_sel_addr[1:0] != 2'b00));
`else
    assign w_misal = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_last_grant     <= 1'b1;
            r_owner          <= 1'b0;
            r_write          <= 1'b0;
            r_misal          <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_size       <= '0;
            r_mem_unsigned   <= 1'b0;
            r_rsp_valid      <= '0;
            r_rsp_err        <= '0;
            r_rsp_rdata[0]   <= '0;
            r_rsp_rdata[1]   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_owner          <= w_grant_p1;
                        r_last_grant     <= w_grant_p1;
                        r_write          <= w_sel_write;
                        r_misal          <= w_misal;
                        r_mem_address    <= 32'(w_sel_addr);
                        r_mem_write_data <= w_sel_wdata;
                        r_mem_size       <= w_sel_size;
                        r_mem_unsigned   <= w_sel_unsigned;
                        r_mem_read       <= !w_sel_write && !w_misal;
                        r_mem_write      <= w_sel_write && !w_misal;
                        r_state          <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rsp_valid[r_owner] <= 1'b1;
                    r_rsp_err[r_owner]   <= r_misal;
                    r_rsp_rdata[r_owner] <= (r_write || r_misal) ? 32'd0 : mem_read_data;
                    r_mem_address        <= '0;
                    r_mem_write_data     <= '0;
                    r_mem_read           <= 1'b0;
                    r_mem_write          <= 1'b0;
                    r_mem_size           <= '0;
                    r_mem_unsigned       <= 1'b0;
                    r_state              <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_ready[r_owner]) begin
                        r_rsp_valid[r_owner] <= 1'b0;
                        r_rsp_err[r_owner]   <= 1'b0;
                        r_rsp_rdata[r_owner] <= '0;
                        r_state              <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_address       = r_mem_address;
    assign mem_write_data    = r_mem_write_data;
    assign mem_read          = r_mem_read;
    assign mem_write         = r_mem_write;
    assign mem_size          = r_mem_size;
    assign mem_unsigned_load = r_mem_unsigned;

    assign p0_rsp_valid = r_rsp_valid[0];
    assign p1_rsp_valid = r_rsp_valid[1];
    assign p0_rsp_rdata = r_rsp_rdata[0];
    assign p1_rsp_rdata = r_rsp_rdata[1];
    assign p0_rsp_err   = r_rsp_err[0];
    assign p1_rsp_err   = r_rsp_err[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin DUT on a byte-memory stub, plus a fixed-priority twin sharing its inputs.
module tb_dmem_arbiter;
    logic        clk;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_req_write, p0_req_unsigned, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
    logic [1:0]  p0_req_size;
    logic        p1_req_valid, p1_req_ready, p1_req_write, p1_req_unsigned, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
    logic [1:0]  p1_req_size;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write, mem_unsigned_load;
    logic [1:0]  mem_size;

    logic        f_p0_req_ready, f_p0_rsp_valid, f_p0_rsp_err;
    logic        f_p1_req_ready, f_p1_rsp_valid, f_p1_rsp_err;
    logic [31:0] f_p0_rsp_rdata, f_p1_rsp_rdata, f_mem_address, f_mem_write_data;
    logic        f_mem_read, f_mem_write, f_mem_unsigned_load;
    logic [1:0]  f_mem_size;
    logic [31:0] f_mem_read_data;

    logic [7:0]  mem [64];
    int          n_vec = 0;
    int          n_err = 0;

    dmem_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_write(p0_req_write), .p0_req_size(p0_req_size),
        .p0_req_unsigned(p0_req_unsigned), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
        .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_write(p1_req_write), .p1_req_size(p1_req_size),
        .p1_req_unsigned(p1_req_unsigned), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
        .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned_load(mem_unsigned_load),
        .mem_read_data(mem_read_data)
    );

    assign f_mem_read_data = 32'd0;

    dmem_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b1)) dut_fixed (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(f_p0_req_ready), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_write(p0_req_write), .p0_req_size(p0_req_size),
        .p0_req_unsigned(p0_req_unsigned), .p0_rsp_valid(f_p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
        .p0_rsp_rdata(f_p0_rsp_rdata), .p0_rsp_err(f_p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(f_p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_write(p1_req_write), .p1_req_size(p1_req_size),
        .p1_req_unsigned(p1_req_unsigned), .p1_rsp_valid(f_p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
        .p1_rsp_rdata(f_p1_rsp_rdata), .p1_rsp_err(f_p1_rsp_err),
        .mem_address(f_mem_address), .mem_write_data(f_mem_write_data), .mem_read(f_mem_read),
        .mem_write(f_mem_write), .mem_size(f_mem_size), .mem_unsigned_load(f_mem_unsigned_load),
        .mem_read_data(f_mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte memory standing in for data_memory: combinational read, write at the clock edge.
    always_comb begin
        logic [5:0] a;
        logic [15:0] h;
        a = mem_address[5:0];
        h = {mem[6'(a + 6'd1)], mem[a]};
        case (mem_size)
            2'b00:   mem_read_data = mem_unsigned_load ? {24'd0, mem[a]} : {{24{mem[a][7]}}, mem[a]};
            2'b01:   mem_read_data = mem_unsigned_load ? {16'd0, h} : {{16{h[15]}}, h};
            default: mem_read_data = {mem[6'(a + 6'd3)], mem[6'(a + 6'd2)], h};
        endcase
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[2] = 8'h1D;
        {mem[7], mem[6], mem[5], mem[4]} = 32'h12345678;
        forever begin
            @(posedge clk);
            if (mem_write) begin
                mem[mem_address[5:0]] = mem_write_data[7:0];
                if (mem_size != 2'b00) mem[6'(mem_address[5:0] + 6'd1)] = mem_write_data[15:8];
                if (mem_size == 2'b10) begin
                    mem[6'(mem_address[5:0] + 6'd2)] = mem_write_data[23:16];
                    mem[6'(mem_address[5:0] + 6'd3)] = mem_write_data[31:24];
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        p0_req_valid = 1'b1; p0_req_addr = 32'd0; p0_req_wdata = 32'd0; p0_req_write = 1'b0;
        p0_req_size = 2'b10; p0_req_unsigned = 1'b0; p0_rsp_ready = 1'b1;
        p1_req_valid = 1'b1; p1_req_addr = 32'd0; p1_req_wdata = 32'd0; p1_req_write = 1'b0;
        p1_req_size = 2'b10; p1_req_unsigned = 1'b0; p1_rsp_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err});
        end
        n_vec++;
        if ({mem_read, mem_write, mem_address, mem_write_data, p0_rsp_rdata} !== 98'd0) begin
            n_err++;
            $display("FAIL reset_mem: rd=%b wr=%b addr=%h wd=%h rdata=%h expected all 0",
                     mem_read, mem_write, mem_address, mem_write_data, p0_rsp_rdata);
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        reset = 1'b0;
        $display("txn reset: outputs checked under reset");
    endtask

    task automatic test_p0_load();
        p0_req_valid = 1'b1; p0_req_addr = 32'h0; p0_req_write = 1'b0; p0_req_size = 2'b01; p0_req_unsigned = 1'b0;
        #1;
        n_vec++;
        if (p0_req_ready !== 1'b1) begin n_err++; $display("FAIL t1_ready: got %b expected 1", p0_req_ready); end
        tick();
        p0_req_valid = 1'b0;
        n_vec++;
        if ({mem_read, mem_write, mem_size, mem_address, p0_rsp_valid} !== {1'b1, 1'b0, 2'b01, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL t1_access: rd=%b wr=%b size=%b addr=%h rsp_valid=%b expected 1 0 01 0 0",
                     mem_read, mem_write, mem_size, mem_address, p0_rsp_valid);
        end
        tick();
        n_vec++;
        if ({mem_read, p0_rsp_valid, p0_rsp_rdata} !== {1'b0, 1'b1, 32'h00000000}) begin
            n_err++;
            $display("FAIL t1_resp: rd=%b rsp_valid=%b rdata=%h expected 0 1 00000000", mem_read, p0_rsp_valid, p0_rsp_rdata);
        end
        tick();
        n_vec++;
        if (p0_rsp_valid !== 1'b0) begin n_err++; $display("FAIL t1_release: rsp_valid=%b expected 0", p0_rsp_valid); end
        $display("txn p0 load half @0x0 rdata=%h", 32'h0);
    endtask

    task automatic test_p1_store_load();
        logic [31:0] exp_rd [2];
        exp_rd[0] = 32'h0000BEEF;
        exp_rd[1] = 32'hFFFFBEEF;
        p1_req_valid = 1'b1; p1_req_addr = 32'h2; p1_req_wdata = 32'h0000BEEF; p1_req_write = 1'b1; p1_req_size = 2'b01;
        #1;
        n_vec++;
        if (p1_req_ready !== 1'b1) begin n_err++; $display("FAIL t2_st_ready: got %b expected 1", p1_req_ready); end
        tick();
        p1_req_valid = 1'b0;
        n_vec++;
        if ({mem_write, mem_read, mem_address, mem_write_data} !== {1'b1, 1'b0, 32'h2, 32'h0000BEEF}) begin
            n_err++;
            $display("FAIL t2_st_access: wr=%b rd=%b addr=%h wd=%h expected 1 0 00000002 0000beef",
                     mem_write, mem_read, mem_address, mem_write_data);
        end
        tick();
        n_vec++;
        if ({mem_write, p1_rsp_valid, p1_rsp_rdata} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL t2_st_resp: wr=%b rsp_valid=%b rdata=%h expected 0 1 0", mem_write, p1_rsp_valid, p1_rsp_rdata);
        end
        tick();
        $display("txn p1 store half 0xbeef @0x2");
        for (int k = 0; k < 2; k++) begin
            p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_unsigned = (k == 0);
            #1;
            n_vec++;
            if (p1_req_ready !== 1'b1) begin n_err++; $display("FAIL t2_ld_ready[%0d]: got %b expected 1", k, p1_req_ready); end
            tick();
            p1_req_valid = 1'b0;
            tick();
            n_vec++;
            if ({p1_rsp_valid, p1_rsp_rdata} !== {1'b1, exp_rd[k]}) begin
                n_err++;
                $display("FAIL t2_ld_rdata[%0d]: valid=%b rdata=%h expected 1 %h", k, p1_rsp_valid, p1_rsp_rdata, exp_rd[k]);
            end
            tick();
            $display("txn p1 load half unsigned=%0d @0x2 rdata=%h", (k == 0), exp_rd[k]);
        end
        p1_req_unsigned = 1'b0;
    endtask

    task automatic test_arbitration();
        p0_req_valid = 1'b1; p0_req_addr = 32'h4; p0_req_write = 1'b0; p0_req_size = 2'b10;
        p1_req_valid = 1'b1; p1_req_addr = 32'h4; p1_req_write = 1'b0; p1_req_size = 2'b10;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_vec++;
            if ({p1_req_ready, p0_req_ready} !== exp_g) begin
                n_err++;
                $display("FAIL t3_rr[%0d]: grant {p1,p0}=%b expected %b", k, {p1_req_ready, p0_req_ready}, exp_g);
            end
            n_vec++;
            if ({f_p1_req_ready, f_p0_req_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL t3_fixed[%0d]: grant {p1,p0}=%b expected 01", k, {f_p1_req_ready, f_p0_req_ready});
            end
            tick(); tick(); tick();
            $display("txn tie %0d rr_grant=p%0d fixed_grant=p0", k, k % 2);
        end
        p0_req_valid = 1'b0;
        #1;
        n_vec++;
        if ({p1_req_ready, f_p1_req_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL t3_p1_alone: rr=%b fixed=%b expected 1 1", p1_req_ready, f_p1_req_ready);
        end
        tick(); tick(); tick();
        p1_req_valid = 1'b0;
        $display("txn p1 alone granted on both arbiters");
    endtask

    task automatic test_rsp_backpressure();
        p0_req_valid = 1'b1; p0_req_addr = 32'h4; p0_req_write = 1'b0; p0_req_size = 2'b10;
        p1_req_valid = 1'b1; p1_req_addr = 32'h0; p1_req_write = 1'b0; p1_req_size = 2'b10;
        p0_rsp_ready = 1'b0;
        #1;
        n_vec++;
        if ({p1_req_ready, p0_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL t4_grant: {p1,p0}=%b expected 01", {p1_req_ready, p0_req_ready});
        end
        tick();
        p0_req_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if ({p0_rsp_valid, p0_rsp_rdata, p1_req_ready, mem_read, mem_write, mem_address} !==
                {1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0}) begin
                n_err++;
                $display("FAIL t4_hold[%0d]: valid=%b rdata=%h p1_ready=%b rd=%b wr=%b addr=%h expected 1 12345678 0 0 0 0",
                         c, p0_rsp_valid, p0_rsp_rdata, p1_req_ready, mem_read, mem_write, mem_address);
            end
            tick();
        end
        p0_rsp_ready = 1'b1;
        tick();
        n_vec++;
        if ({p0_rsp_valid, p1_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL t4_release: p0_valid=%b p1_ready=%b expected 0 1", p0_rsp_valid, p1_req_ready);
        end
        tick();
        p1_req_valid = 1'b0;
        tick(); tick();
        $display("txn p0 held response 5 cycles rdata=12345678, then p1 served");
    endtask

    task automatic test_reset_mid_access();
        p0_req_valid = 1'b1; p0_req_addr = 32'h8; p0_req_wdata = 32'hDEADBEEF; p0_req_write = 1'b1; p0_req_size = 2'b10;
        #1;
        tick();
        p0_req_valid = 1'b0;
        n_vec++;
        if (mem_write !== 1'b1) begin n_err++; $display("FAIL t5_access: mem_write=%b expected 1", mem_write); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({mem_write, mem_read, p0_rsp_valid, p1_rsp_valid, f_mem_write, f_p0_rsp_valid} !== 6'd0) begin
            n_err++;
            $display("FAIL t5_async: wr=%b rd=%b v0=%b v1=%b f_wr=%b f_v0=%b expected all 0",
                     mem_write, mem_read, p0_rsp_valid, p1_rsp_valid, f_mem_write, f_p0_rsp_valid);
        end
        tick();
        reset = 1'b0;
        n_vec++;
        if ({mem[11], mem[10], mem[9], mem[8]} !== 32'h0) begin
            n_err++;
            $display("FAIL t5_nowrite: mem[8]=%h expected 00000000", {mem[11], mem[10], mem[9], mem[8]});
        end
        p0_req_valid = 1'b1; p0_req_write = 1'b0;
        #1;
        n_vec++;
        if (p0_req_ready !== 1'b1) begin n_err++; $display("FAIL t5_idle: p0_ready=%b expected 1", p0_req_ready); end
        tick();
        p0_req_valid = 1'b0;
        tick();
        n_vec++;
        if ({p0_rsp_valid, p0_rsp_rdata} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL t5_readback: valid=%b rdata=%h expected 1 00000000", p0_rsp_valid, p0_rsp_rdata);
        end
        tick();
        $display("txn reset during store access, store dropped");
    endtask

    task automatic test_misaligned();
        logic exp_rd;
        logic exp_err;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        exp_rd = 1'b0; exp_err = 1'b1;
`else
        exp_rd = 1'b1; exp_err = 1'b0;
`endif
        p0_req_valid = 1'b1; p0_req_addr = 32'h1; p0_req_write = 1'b0; p0_req_size = 2'b10;
        #1;
        tick();
        p0_req_valid = 1'b0;
        n_vec++;
        if ({mem_read, mem_write} !== {exp_rd, 1'b0}) begin
            n_err++;
            $display("FAIL t6_access: rd=%b wr=%b expected %b 0", mem_read, mem_write, exp_rd);
        end
        tick();
        n_vec++;
        if ({p0_rsp_valid, p0_rsp_err} !== {1'b1, exp_err}) begin
            n_err++;
            $display("FAIL t6_err: valid=%b err=%b expected 1 %b", p0_rsp_valid, p0_rsp_err, exp_err);
        end
        if (exp_err) begin
            n_vec++;
            if (p0_rsp_rdata !== 32'h0) begin n_err++; $display("FAIL t6_rdata: rdata=%h expected 0", p0_rsp_rdata); end
        end
        tick();
        $display("txn p0 load word @0x1 err=%b", exp_err);
    endtask

    initial begin
        test_reset();
        test_p0_load();
        test_p1_store_load();
        test_arbitration();
        test_rsp_backpressure();
        test_reset_mid_access();
        test_misaligned();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
